// File: rtl/pipe_stage_chain_if.sv
// Handshake and tap bundle for pipe_stage_chain.
// The master side drives the payload and stall/flush controls; the slave
// side (the chain) drives readiness, per-stage taps and occupancy.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 4
);
  logic                   in_valid_i;
  logic [WIDTH-1:0]       in_data_i;
  logic                   in_ready_o;
  logic [DEPTH-1:0]       stall_mask_i;
  logic [DEPTH-1:0]       flush_mask_i;
  logic [DEPTH-1:0]       stage_valid_o;
  logic [DEPTH*WIDTH-1:0] stage_data_o;
  logic                   out_valid_o;
  logic [WIDTH-1:0]       out_data_o;
  logic [CNTW-1:0]        occ_o;

  modport master (
    output in_valid_i, in_data_i, stall_mask_i, flush_mask_i,
    input  in_ready_o, stage_valid_o, stage_data_o, out_valid_o, out_data_o, occ_o
  );

  modport slave (
    input  in_valid_i, in_data_i, stall_mask_i, flush_mask_i,
    output in_ready_o, stage_valid_o, stage_data_o, out_valid_o, out_data_o, occ_o
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline registers with per-stage valid, stall, flush and
// bubble insertion. Stage k feeds CPU stage k+1; every stage is tapped.
// A stall on stage k holds stage k and everything upstream of it; the first
// non-held stage below a held one receives a bubble. Bubbles and flushed
// stages always carry all-zero data so they decode as NOP downstream.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 4
) (
  input logic               clk_i,
  input logic               rst_n,
  pipe_stage_chain_if.slave bus
);

  logic [DEPTH-1:0]       hold;
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       valid_d;
  logic [DEPTH*WIDTH-1:0] data_q;
  logic [DEPTH*WIDTH-1:0] data_d;
  logic [CNTW-1:0]        occ_q;
  logic [CNTW-1:0]        occ_d;

  // A stage holds if it or any stage downstream of it is stalled.
  for (genvar k = 0; k < DEPTH; k++) begin : g_hold
    assign hold[k] = |bus.stall_mask_i[DEPTH-1:k];
  end

  // Next-state selection per stage: flush, then hold, then load/bubble/shift.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    if (bus.flush_mask_i[0]) begin
      valid_d[0]         = 1'b0;
      data_d[WIDTH-1:0]  = '0;
    end else if (!hold[0]) begin
      valid_d[0]         = bus.in_valid_i;
      data_d[WIDTH-1:0]  = bus.in_valid_i ? bus.in_data_i : '0;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (bus.flush_mask_i[k]) begin
        valid_d[k]                = 1'b0;
        data_d[k*WIDTH +: WIDTH]  = '0;
      end else if (!hold[k]) begin
        if (hold[k-1]) begin
          valid_d[k]               = 1'b0;
          data_d[k*WIDTH +: WIDTH] = '0;
        end else begin
          valid_d[k]               = valid_q[k-1];
          data_d[k*WIDTH +: WIDTH] = data_q[(k-1)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Occupancy tracks the valid vector being loaded, so it is never stale.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + CNTW'(valid_d[k]);
    end
  end

  // Stage registers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready_o    = ~hold[0];
  assign bus.stage_valid_o = valid_q;
  assign bus.stage_data_o  = data_q;
  assign bus.out_valid_o   = valid_q[DEPTH-1];
  assign bus.out_data_o    = data_q[(DEPTH-1)*WIDTH +: WIDTH];
  assign bus.occ_o         = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and randomised checks of pipe_stage_chain at DEPTH 4/2/8.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [31:0] DA = 32'hA0A0_0001;
  localparam logic [31:0] DB = 32'hB0B0_0002;
  localparam logic [31:0] DC = 32'hC0C0_0003;
  localparam logic [31:0] DD = 32'hD0D0_0004;

  always #5 clk = ~clk;

  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(4), .CNTW(4)) if_a ();
  pipe_stage_chain_if #(.WIDTH(8),  .DEPTH(2), .CNTW(2)) if_b ();
  pipe_stage_chain_if #(.WIDTH(8),  .DEPTH(8), .CNTW(4)) if_c ();

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNTW(4)) dut_a (.clk_i(clk), .rst_n(rst_n), .bus(if_a.slave));
  pipe_stage_chain #(.WIDTH(8),  .DEPTH(2), .CNTW(2)) dut_b (.clk_i(clk), .rst_n(rst_n), .bus(if_b.slave));
  pipe_stage_chain #(.WIDTH(8),  .DEPTH(8), .CNTW(4)) dut_c (.clk_i(clk), .rst_n(rst_n), .bus(if_c.slave));

  // Reference state for the two WIDTH=8 chains (index 0: DEPTH 2, 1: DEPTH 8).
  logic [7:0] m_v [2];
  logic [7:0] m_d [2][8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic [3:0] st, input logic [3:0] fl);
    if_a.in_valid_i   = v;
    if_a.in_data_i    = d;
    if_a.stall_mask_i = st;
    if_a.flush_mask_i = fl;
  endtask

  task automatic fill_a();
    drive_a(1'b1, DA, 4'b0, 4'b0); tick();
    drive_a(1'b1, DB, 4'b0, 4'b0); tick();
    drive_a(1'b1, DC, 4'b0, 4'b0); tick();
    drive_a(1'b1, DD, 4'b0, 4'b0); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b0, 32'h0, 4'b0, 4'b0);
    if_b.in_valid_i = 1'b0; if_b.in_data_i = 8'h0; if_b.stall_mask_i = '0; if_b.flush_mask_i = '0;
    if_c.in_valid_i = 1'b0; if_c.in_data_i = 8'h0; if_c.stall_mask_i = '0; if_c.flush_mask_i = '0;
    #2;
    vectors++;
    if (if_a.stage_valid_o !== 4'b0 || if_a.stage_data_o !== 128'h0 || if_a.occ_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_a: valid=%b occ=%0d data=%h required all zero", if_a.stage_valid_o, if_a.occ_o, if_a.stage_data_o);
    end
    vectors++;
    if (if_b.stage_valid_o !== 2'b0 || if_c.stage_valid_o !== 8'b0 || if_c.stage_data_o !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bc: vb=%b vc=%b dc=%h required zero", if_b.stage_valid_o, if_c.stage_valid_o, if_c.stage_data_o);
    end
    vectors++;
    if (if_a.in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", if_a.in_ready_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [31:0] din  [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    logic        vin  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] eout [8] = '{0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0};
    logic        eov  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic [3:0]  eocc [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      drive_a(vin[i], din[i], 4'b0, 4'b0);
      tick();
      vectors++;
      if (if_a.out_valid_o !== eov[i] || if_a.out_data_o !== eout[i] || if_a.occ_o !== eocc[i]) begin
        miscompares++;
        $display("FAIL fill_drain[%0d]: ov=%b od=%h occ=%0d required ov=%b od=%h occ=%0d",
                 i, if_a.out_valid_o, if_a.out_data_o, if_a.occ_o, eov[i], eout[i], eocc[i]);
      end
      if (i == 3) begin
        vectors++;
        if (if_a.stage_data_o !== 128'h00000011_00000022_00000033_00000044) begin
          miscompares++;
          $display("FAIL fill_taps: got %h required 00000011_00000022_00000033_00000044", if_a.stage_data_o);
        end
      end
    end
  endtask

  task automatic test_mid_stall();
    fill_a();
    drive_a(1'b0, 32'h0, 4'b0010, 4'b0);
    #1;
    vectors++;
    if (if_a.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_ready: got %b required 0", if_a.in_ready_o);
    end
    tick();
    vectors++;
    if (if_a.stage_data_o !== {DB, 32'h0, DC, DD} || if_a.stage_valid_o !== 4'b1011 || if_a.occ_o !== 4'd3) begin
      miscompares++;
      $display("FAIL stall_step: data=%h valid=%b occ=%0d required data=%h valid=1011 occ=3",
               if_a.stage_data_o, if_a.stage_valid_o, if_a.occ_o, {DB, 32'h0, DC, DD});
    end
    drive_a(1'b0, 32'h0, 4'b0, 4'b0);
    tick();
    vectors++;
    if (if_a.stage_data_o !== {32'h0, DC, DD, 32'h0} || if_a.stage_valid_o !== 4'b0110 || if_a.occ_o !== 4'd2) begin
      miscompares++;
      $display("FAIL stall_resume: data=%h valid=%b occ=%0d required valid=0110 occ=2",
               if_a.stage_data_o, if_a.stage_valid_o, if_a.occ_o);
    end
    tick(); tick(); tick();
    vectors++;
    if (if_a.occ_o !== 4'd0 || if_a.stage_valid_o !== 4'b0) begin
      miscompares++;
      $display("FAIL stall_drain: occ=%0d valid=%b required 0", if_a.occ_o, if_a.stage_valid_o);
    end
  endtask

  task automatic test_flush();
    drive_a(1'b1, 32'h1111, 4'b0, 4'b0); tick();
    drive_a(1'b1, 32'hBEEF, 4'b0, 4'b0); tick();
    drive_a(1'b1, 32'h3333, 4'b0, 4'b0); tick();
    drive_a(1'b0, 32'h0, 4'b0, 4'b0100);
    tick();
    vectors++;
    if (if_a.stage_data_o !== {32'h1111, 32'h0, 32'h3333, 32'h0} || if_a.stage_valid_o !== 4'b1010 || if_a.occ_o !== 4'd2) begin
      miscompares++;
      $display("FAIL flush_step: data=%h valid=%b occ=%0d required valid=1010 occ=2",
               if_a.stage_data_o, if_a.stage_valid_o, if_a.occ_o);
    end
    drive_a(1'b0, 32'h0, 4'b0, 4'b0);
    tick();
    vectors++;
    if (if_a.out_valid_o !== 1'b0 || if_a.out_data_o !== 32'h0 || if_a.stage_data_o[95:64] !== 32'h3333) begin
      miscompares++;
      $display("FAIL flush_gap: ov=%b od=%h s2=%h required ov=0 od=0 s2=3333",
               if_a.out_valid_o, if_a.out_data_o, if_a.stage_data_o[95:64]);
    end
    tick();
    vectors++;
    if (if_a.out_valid_o !== 1'b1 || if_a.out_data_o !== 32'h3333) begin
      miscompares++;
      $display("FAIL flush_next: ov=%b od=%h required ov=1 od=3333", if_a.out_valid_o, if_a.out_data_o);
    end
    tick();
    vectors++;
    if (if_a.occ_o !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_drain: occ=%0d required 0", if_a.occ_o);
    end
  endtask

  task automatic test_flush_stall();
    fill_a();
    drive_a(1'b0, 32'h0, 4'b0100, 4'b0100);
    #1;
    vectors++;
    if (if_a.in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fs_ready: got %b required 0", if_a.in_ready_o);
    end
    tick();
    vectors++;
    if (if_a.stage_data_o !== {32'h0, 32'h0, DC, DD} || if_a.stage_valid_o !== 4'b0011 || if_a.occ_o !== 4'd2) begin
      miscompares++;
      $display("FAIL fs_step: data=%h valid=%b occ=%0d required valid=0011 occ=2",
               if_a.stage_data_o, if_a.stage_valid_o, if_a.occ_o);
    end
    drive_a(1'b0, 32'h0, 4'b0, 4'b0);
    tick();
    vectors++;
    if (if_a.stage_data_o !== {32'h0, DC, DD, 32'h0} || if_a.occ_o !== 4'd2) begin
      miscompares++;
      $display("FAIL fs_resume: data=%h occ=%0d required occ=2", if_a.stage_data_o, if_a.occ_o);
    end
    tick(); tick(); tick();
    vectors++;
    if (if_a.occ_o !== 4'd0) begin
      miscompares++;
      $display("FAIL fs_drain: occ=%0d required 0", if_a.occ_o);
    end
  endtask

  task automatic test_reset_mid();
    fill_a();
    drive_a(1'b0, 32'h0, 4'b0, 4'b0);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (if_a.stage_valid_o !== 4'b0 || if_a.stage_data_o !== 128'h0 || if_a.occ_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b occ=%0d data=%h required all zero",
               if_a.stage_valid_o, if_a.occ_o, if_a.stage_data_o);
    end
    tick();
    rst_n = 1'b1;
    drive_a(1'b1, 32'h5A, 4'b0, 4'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      drive_a(1'b0, 32'h0, 4'b0, 4'b0);
      vectors++;
      if (if_a.out_valid_o !== (e == 4) || if_a.out_data_o !== ((e == 4) ? 32'h5A : 32'h0)) begin
        miscompares++;
        $display("FAIL reset_latency[%0d]: ov=%b od=%h required ov=%b", e, if_a.out_valid_o, if_a.out_data_o, e == 4);
      end
    end
    tick();
  endtask

  task automatic model_step(input int d, input int dep, input logic iv, input logic [7:0] id,
                            input logic [7:0] st, input logic [7:0] fl);
    logic h;
    h = 1'b0;
    for (int k = dep - 1; k >= 0; k--) begin
      h = h | st[k];
      if (fl[k]) begin
        m_v[d][k] = 1'b0;
        m_d[d][k] = 8'h0;
      end else if (!h) begin
        if (k == 0) begin
          m_v[d][0] = iv;
          m_d[d][0] = iv ? id : 8'h0;
        end else if (st[k-1]) begin
          m_v[d][k] = 1'b0;
          m_d[d][k] = 8'h0;
        end else begin
          m_v[d][k] = m_v[d][k-1];
          m_d[d][k] = m_d[d][k-1];
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic       ivb, ivc;
    logic [7:0] idb, idc, stb, stc, flb, flc;
    logic [63:0] expd;
    logic [3:0]  pop;
    for (int d = 0; d < 2; d++) begin
      m_v[d] = '0;
      for (int k = 0; k < 8; k++) m_d[d][k] = 8'h0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      ivb = ($urandom_range(0, 3) != 0);
      ivc = ($urandom_range(0, 3) != 0);
      idb = 8'($urandom);
      idc = 8'($urandom);
      stb = 8'($urandom & $urandom & $urandom) & 8'h03;
      stc = 8'($urandom & $urandom & $urandom & $urandom);
      flb = 8'($urandom & $urandom & $urandom) & 8'h03;
      flc = 8'($urandom & $urandom & $urandom & $urandom);
      if_b.in_valid_i = ivb; if_b.in_data_i = idb; if_b.stall_mask_i = stb[1:0]; if_b.flush_mask_i = flb[1:0];
      if_c.in_valid_i = ivc; if_c.in_data_i = idc; if_c.stall_mask_i = stc;      if_c.flush_mask_i = flc;
      #1;
      vectors++;
      if (if_b.in_ready_o !== (stb == 8'h0) || if_c.in_ready_o !== (stc == 8'h0)) begin
        miscompares++;
        $display("FAIL sweep_ready[%0d]: rb=%b rc=%b stb=%b stc=%b", cyc, if_b.in_ready_o, if_c.in_ready_o, stb, stc);
      end
      tick();
      model_step(0, 2, ivb, idb, stb, flb);
      model_step(1, 8, ivc, idc, stc, flc);

      expd = '0; pop = '0;
      for (int k = 0; k < 2; k++) begin
        expd[k*8 +: 8] = m_d[0][k];
        pop = pop + 4'(m_v[0][k]);
      end
      vectors++;
      if (if_b.stage_valid_o !== m_v[0][1:0] || if_b.stage_data_o !== expd[15:0] || if_b.occ_o !== pop[1:0]) begin
        miscompares++;
        $display("FAIL sweep_d2[%0d]: v=%b d=%h occ=%0d required v=%b d=%h occ=%0d",
                 cyc, if_b.stage_valid_o, if_b.stage_data_o, if_b.occ_o, m_v[0][1:0], expd[15:0], pop[1:0]);
      end

      expd = '0; pop = '0;
      for (int k = 0; k < 8; k++) begin
        expd[k*8 +: 8] = m_d[1][k];
        pop = pop + 4'(m_v[1][k]);
      end
      vectors++;
      if (if_c.stage_valid_o !== m_v[1] || if_c.stage_data_o !== expd || if_c.occ_o !== pop
          || if_c.out_valid_o !== m_v[1][7] || if_c.out_data_o !== m_d[1][7]) begin
        miscompares++;
        $display("FAIL sweep_d8[%0d]: v=%b d=%h occ=%0d required v=%b d=%h occ=%0d",
                 cyc, if_c.stage_valid_o, if_c.stage_data_o, if_c.occ_o, m_v[1], expd, pop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_mid_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
